// File: rtl/cache_mem_resp.sv
// Responder side of the cache memory interface: 32x8 storage with valid bits,
// hit/miss reporting, saturating statistics and a multi-cycle flush sweep.
module cache_mem_resp #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              hit,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DEPTH-1:0]    valid_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [DATA_W-1:0]   data_out_d;
  logic                rd_valid_d, hit_d, busy_d, err_d;
  logic [CNT_W-1:0]    hit_cnt_d, miss_cnt_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                valid_set, valid_clr;

  // Next-state, storage write strobes and registered-output next values
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_out_d = data_out;
    rd_valid_d = 1'b0;
    hit_d      = hit;
    busy_d     = busy;
    err_d      = 1'b0;
    hit_cnt_d  = hit_cnt;
    miss_cnt_d = miss_cnt;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = data_in;
    valid_set  = 1'b0;
    valid_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush) begin
          // Flush wins; any request presented alongside it is dropped
          state_d = FLUSH;
          idx_d   = '0;
          busy_d  = 1'b1;
          err_d   = wr_en | rd_en;
        end else begin
          if (wr_en) begin
            mem_we    = 1'b1;
            valid_set = 1'b1;
          end
          if (rd_en && wr_en) begin
            err_d = 1'b1;
          end else if (rd_en) begin
            rd_valid_d = 1'b1;
            if (valid_q[addr]) begin
              data_out_d = mem[addr];
              hit_d      = 1'b1;
              if (hit_cnt != '1) hit_cnt_d = hit_cnt + CNT_W'(1);
            end else begin
              data_out_d = '0;
              hit_d      = 1'b0;
              if (miss_cnt != '1) miss_cnt_d = miss_cnt + CNT_W'(1);
            end
          end
        end
      end
      FLUSH: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = '0;
        valid_clr = 1'b1;
        idx_d     = idx_q + ADDR_W'(1);
        err_d     = wr_en | rd_en;
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, valid bits and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      valid_q  <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      hit      <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_out <= data_out_d;
      rd_valid <= rd_valid_d;
      hit      <= hit_d;
      busy     <= busy_d;
      err      <= err_d;
      hit_cnt  <= hit_cnt_d;
      miss_cnt <= miss_cnt_d;
      if (valid_set)      valid_q[mem_waddr] <= 1'b1;
      else if (valid_clr) valid_q[mem_waddr] <= 1'b0;
    end
  end

  // Storage array is not reset; valid bits mask stale contents
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_cache_mem_resp.sv
// Self-checking bench for cache_mem_resp: vector table plus scoreboarded
// sequences for flush, reset-during-flush and counter saturation.
module tb_cache_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  addr;
  logic [7:0]  data_in;
  logic        wr_en, rd_en, flush;
  logic [7:0]  data_out;
  logic        rd_valid, hit, busy, err;
  logic [15:0] hit_cnt, miss_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       h;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       wr;
    logic       rd;
    logic [4:0] a;
    logic [7:0] din;
    logic       exp_rv;
    logic       exp_err;
    logic       exp_hit;
    logic [7:0] exp_dout;
  } vec_t;
  vec_t vecs[8];

  cache_mem_resp dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .data_out(data_out), .rd_valid(rd_valid), .hit(hit), .busy(busy),
    .err(err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    chk("sb_rd_valid", 32'(rd_valid), 32'(sb.size() != 0));
    if (rd_valid && sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_data", 32'(data_out), 32'(e.d));
      chk("sb_hit", 32'(hit), 32'(e.h));
    end
    sb.delete();
  endtask

  // Drive one request at the falling edge, let the DUT sample it, check at the next falling edge
  task automatic step(input logic w, input logic r, input logic f,
                      input logic [4:0] a, input logic [7:0] d);
    wr_en = w; rd_en = r; flush = f; addr = a; data_in = d;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    sb_check();
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] ed, input logic eh);
    sb.push_back('{d: ed, h: eh});
    step(1'b0, 1'b1, 1'b0, a, 8'h00);
    chk("rd_err", 32'(err), 32'(0));
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    step(1'b1, 1'b0, 1'b0, a, d);
    chk("wr_err", 32'(err), 32'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1; addr = '0; data_in = '0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;

    vecs[0] = '{wr:1'b0, rd:1'b1, a:5'd7, din:8'h00, exp_rv:1'b1, exp_err:1'b0, exp_hit:1'b0, exp_dout:8'h00};
    vecs[1] = '{wr:1'b1, rd:1'b0, a:5'd7, din:8'h3C, exp_rv:1'b0, exp_err:1'b0, exp_hit:1'b0, exp_dout:8'h00};
    vecs[2] = '{wr:1'b0, rd:1'b1, a:5'd7, din:8'h00, exp_rv:1'b1, exp_err:1'b0, exp_hit:1'b1, exp_dout:8'h3C};
    vecs[3] = '{wr:1'b1, rd:1'b0, a:5'd5, din:8'hA5, exp_rv:1'b0, exp_err:1'b0, exp_hit:1'b1, exp_dout:8'h3C};
    vecs[4] = '{wr:1'b0, rd:1'b1, a:5'd5, din:8'h00, exp_rv:1'b1, exp_err:1'b0, exp_hit:1'b1, exp_dout:8'hA5};
    vecs[5] = '{wr:1'b1, rd:1'b1, a:5'd3, din:8'h55, exp_rv:1'b0, exp_err:1'b1, exp_hit:1'b1, exp_dout:8'hA5};
    vecs[6] = '{wr:1'b0, rd:1'b1, a:5'd3, din:8'h00, exp_rv:1'b1, exp_err:1'b0, exp_hit:1'b1, exp_dout:8'h55};
    vecs[7] = '{wr:1'b0, rd:1'b1, a:5'd0, din:8'h00, exp_rv:1'b1, exp_err:1'b0, exp_hit:1'b0, exp_dout:8'h00};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_hit", 32'(hit), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_hit_cnt", 32'(hit_cnt), 32'(0));
    chk("rst_miss_cnt", 32'(miss_cnt), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic read/write/conflict vectors
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].exp_rv) sb.push_back('{d: vecs[i].exp_dout, h: vecs[i].exp_hit});
      step(vecs[i].wr, vecs[i].rd, 1'b0, vecs[i].a, vecs[i].din);
      chk($sformatf("vec%0d_rv", i), 32'(rd_valid), 32'(vecs[i].exp_rv));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
      chk($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].exp_dout));
    end
    chk("vec_hit_cnt", 32'(hit_cnt), 32'(3));
    chk("vec_miss_cnt", 32'(miss_cnt), 32'(2));

    // Fill every entry, then flush
    for (int i = 0; i < 32; i++) wr(5'(i), 8'(i) ^ 8'hFF);
    rd(5'd10, 8'hF5, 1'b1);
    rd(5'd31, 8'hE0, 1'b1);
    rd(5'd10, 8'hF5, 1'b1);
    step(1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
    chk("flush_busy_start", 32'(busy), 32'(1));
    chk("flush_start_err", 32'(err), 32'(0));
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 5) begin
        step(1'b0, 1'b1, 1'b0, 5'd2, 8'h00);
        chk("flush_rd_err", 32'(err), 32'(1));
      end else if (n == 6) begin
        chk("flush_err_pulse", 32'(err), 32'(1));
        step(1'b1, 1'b0, 1'b1, 5'd4, 8'h77);
        chk("flush_wr_err", 32'(err), 32'(1));
      end else begin
        step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
      end
    end
    chk("flush_busy_cycles", 32'(n), 32'(32));
    chk("flush_busy_end", 32'(busy), 32'(0));
    chk("flush_hold_dout", 32'(data_out), 32'(8'hF5));
    chk("flush_hold_hit", 32'(hit), 32'(1));
    rd(5'd0, 8'h00, 1'b0);
    rd(5'd4, 8'h00, 1'b0);
    rd(5'd31, 8'h00, 1'b0);
    chk("flush_hit_cnt", 32'(hit_cnt), 32'(6));
    chk("flush_miss_cnt", 32'(miss_cnt), 32'(5));

    // Reset in the middle of a sweep
    wr(5'd0, 8'h11);
    wr(5'd31, 8'h22);
    rd(5'd31, 8'h22, 1'b1);
    step(1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
    repeat (10) step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    chk("mid_busy_before", 32'(busy), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_hit_cnt", 32'(hit_cnt), 32'(0));
    chk("mid_rst_miss_cnt", 32'(miss_cnt), 32'(0));
    chk("mid_rst_dout", 32'(data_out), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(5'd0, 8'h00, 1'b0);
    rd(5'd31, 8'h00, 1'b0);
    chk("mid_busy_after", 32'(busy), 32'(0));
    chk("mid_miss_cnt", 32'(miss_cnt), 32'(2));
    chk("mid_hit_cnt", 32'(hit_cnt), 32'(0));

    // Hit counter saturation
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr(5'd4, 8'h44);
    addr = 5'd4; rd_en = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat_hit_cnt_pre", 32'(hit_cnt), 32'(16'hFFFE));
    repeat (6) @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    chk("sat_hit_cnt", 32'(hit_cnt), 32'(16'hFFFF));
    chk("sat_miss_cnt", 32'(miss_cnt), 32'(0));
    chk("sat_dout", 32'(data_out), 32'(8'h44));
    rd(5'd4, 8'h44, 1'b1);
    chk("sat_hit_cnt_hold", 32'(hit_cnt), 32'(16'hFFFF));
    rd(5'd9, 8'h00, 1'b0);
    chk("sat_miss_inc", 32'(miss_cnt), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_resp.md
# cache_mem_resp

Responder end of the cache memory interface: a 32-entry × 8-bit storage array that services single-cycle write and read requests issued by the testbench/initiator side. It tracks per-entry valid bits, reports hit/miss on every read, keeps saturating hit/miss statistics, and supports a multi-cycle flush sweep with a busy indication. It sits on the memory side of the interface, directly below the initiator's write/read tasks.

## Interface

- ADDR_W, 5, address width; depth = 2**ADDR_W (32)
- DATA_W, 8, data width
- CNT_W, 16, hit/miss counter width

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- addr  input  ADDR_W  entry index for the current request
- data_in  input  DATA_W  write data
- wr_en  input  1  write request, sampled at rising clk
- rd_en  input  1  read request, sampled at rising clk
- flush  input  1  start invalidate/clear sweep (level sampled; acted on only in IDLE)
- data_out  output  DATA_W  read data, registered
- rd_valid  output  1  one-cycle pulse: data_out/hit updated this cycle
- hit  output  1  registered; 1 = last read hit a valid entry
- busy  output  1  high while flush sweep is in progress
- err  output  1  one-cycle pulse on an illegal or dropped request
- hit_cnt  output  CNT_W  saturating read-hit count
- miss_cnt  output  CNT_W  saturating read-miss count

## Operation

- State machine: IDLE, FLUSH. Reset → IDLE.
- IDLE, wr_en=1, rd_en=0: mem[addr] ← data_in, valid[addr] ← 1. No change to data_out.
- IDLE, rd_en=1, wr_en=0: valid[addr]=1 → data_out ← mem[addr], hit ← 1, hit_cnt+1; valid[addr]=0 → data_out ← 0x00, hit ← 0, miss_cnt+1. rd_valid pulses.
- IDLE, wr_en=1 and rd_en=1: write performed as above, read dropped, err pulses, rd_valid stays 0, data_out/hit hold.
- IDLE, flush=1: enter FLUSH next cycle with sweep index 0; any wr_en/rd_en in the same cycle is dropped with err pulse.
- FLUSH: each cycle mem[idx] ← 0x00, valid[idx] ← 0, idx+1. After idx = 31 is cleared → IDLE. Sweep occupies exactly 32 cycles.
- FLUSH, any wr_en or rd_en: request dropped, err pulses, no state change besides sweep. flush input ignored.
- Counters saturate at 2**CNT_W−1; cleared only by rst (not by flush).
- data_out and hit hold their values between reads, including across a flush.

## Timing

- Reset values: data_out=0x00, rd_valid=0, hit=0, busy=0, err=0, hit_cnt=0, miss_cnt=0, all valid bits 0, state IDLE, idx 0. Storage array is not reset (valid bits mask it).
- Read latency 1: request sampled at rising edge N; data_out, hit, rd_valid valid after edge N, stable at the following falling edge (initiator samples there).
- Write takes effect at edge N; a read of the same address sampled at edge N+1 returns the new data (hit).
- busy asserts after the edge that accepts flush, deasserts after the edge clearing entry 31; busy high for 32 cycles.
- err and rd_valid are single-cycle pulses registered on the request edge.
- rst mid-flush: immediate return to IDLE, busy=0, all valid bits cleared; subsequent reads miss and return 0x00.

## Test plan

- Write addr 5 = 0xA5, then read addr 5 → data_out=0xA5, hit=1, rd_valid pulse one cycle after the read edge, hit_cnt=1.
- After reset, read addr 7 → data_out=0x00, hit=0, miss_cnt=1; write addr 7 = 0x3C then read → 0x3C, hit=1.
- wr_en and rd_en both high, addr 3, data 0x55 → err pulse, no rd_valid, data_out unchanged; subsequent read addr 3 → 0x55, hit.
- Write all 32 entries with addr^0xFF, pulse flush → busy high for exactly 32 cycles; read issued during busy → err, no rd_valid; after busy drops, read any addr → 0x00, hit=0.
- Assert rst at sweep cycle 10 → busy=0 and counters 0 immediately; reads of addr 0 and 31 both miss with 0x00.
- Issue 65540 reads to a valid entry (CNT_W=16) → hit_cnt saturates at 0xFFFF, miss_cnt stays 0.
